// File: rtl/lab3_mem_line_to_word_adapter_if.sv
// Stream handshakes between the cache-side 16B line port and the memory-side 4B word port.
interface lab3_mem_line_to_word_adapter_if;
    logic         cache2mem_reqstream_val;
    logic         cache2mem_reqstream_rdy;
    logic [175:0] cache2mem_reqstream_msg;
    logic         cache2mem_respstream_val;
    logic         cache2mem_respstream_rdy;
    logic [145:0] cache2mem_respstream_msg;
    logic         mem_reqstream_val;
    logic         mem_reqstream_rdy;
    logic [77:0]  mem_reqstream_msg;
    logic         mem_respstream_val;
    logic         mem_respstream_rdy;
    logic [47:0]  mem_respstream_msg;

    // Adapter view
    modport slave (
        input  cache2mem_reqstream_val, cache2mem_reqstream_msg, cache2mem_respstream_rdy,
               mem_reqstream_rdy, mem_respstream_val, mem_respstream_msg,
        output cache2mem_reqstream_rdy, cache2mem_respstream_val, cache2mem_respstream_msg,
               mem_reqstream_val, mem_reqstream_msg, mem_respstream_rdy
    );

    // Cache + memory environment view
    modport master (
        output cache2mem_reqstream_val, cache2mem_reqstream_msg, cache2mem_respstream_rdy,
               mem_reqstream_rdy, mem_respstream_val, mem_respstream_msg,
        input  cache2mem_reqstream_rdy, cache2mem_respstream_val, cache2mem_respstream_msg,
               mem_reqstream_val, mem_reqstream_msg, mem_respstream_rdy
    );
endinterface

// File: rtl/lab3_mem_line_to_word_adapter.sv
// Splits one 16B cache line request into four in-order 4B memory requests and
// reassembles the four word responses into a single 16B line response.
module lab3_mem_line_to_word_adapter (
    input logic                            clk,
    input logic                            reset,
    lab3_mem_line_to_word_adapter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;
    localparam int NUM_BEATS = 4;

    state_t       state;
    state_t       state_next;
    logic [3:0]   lat_type;
    logic [7:0]   lat_opaque;
    logic [27:0]  lat_base;
    logic [127:0] lat_data;
    logic [127:0] asm_data;
    logic [2:0]   req_cnt;
    logic [2:0]   resp_cnt;

    logic         line_req_rdy;
    logic         word_req_val;
    logic         word_resp_rdy;
    logic         line_resp_val;
    logic         line_req_xfer;
    logic         word_req_xfer;
    logic         word_resp_xfer;
    logic         line_resp_xfer;
    logic [1:0]   req_idx;
    logic [1:0]   resp_idx;
    logic [77:0]  word_req_msg;
    logic [145:0] line_resp_msg;
    logic         unused_fields;

    assign req_idx  = req_cnt[1:0];
    assign resp_idx = resp_cnt[1:0];

    assign line_req_rdy  = (state == IDLE);
    assign word_req_val  = (state == XFER) && (req_cnt < 3'(NUM_BEATS));
    // A response is only accepted once its request has gone out.
    assign word_resp_rdy = (state == XFER) && (resp_cnt != req_cnt);
    assign line_resp_val = (state == RESP);

    assign line_req_xfer  = line_req_rdy  && bus.cache2mem_reqstream_val;
    assign word_req_xfer  = word_req_val  && bus.mem_reqstream_rdy;
    assign word_resp_xfer = word_resp_rdy && bus.mem_respstream_val;
    assign line_resp_xfer = line_resp_val && bus.cache2mem_respstream_rdy;

    // {type_, opaque, addr, len, data}; beat index doubles as opaque tag and word offset
    assign word_req_msg  = {lat_type, 6'b0, req_idx, lat_base, req_idx, 2'b00, 2'b00,
                            lat_data[{req_idx, 5'b0} +: 32]};
    assign line_resp_msg = {lat_type, lat_opaque, 2'b00, 4'h0, asm_data};

    // Request len, low address nibble and all response metadata are don't-care.
    assign unused_fields = ^{bus.cache2mem_reqstream_msg[135:128], bus.mem_respstream_msg[47:32]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (line_req_xfer) state_next = XFER;
            XFER:    if (word_resp_xfer && (resp_cnt == 3'(NUM_BEATS - 1))) state_next = RESP;
            RESP:    if (line_resp_xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_type   <= '0;
            lat_opaque <= '0;
            lat_base   <= '0;
            lat_data   <= '0;
            asm_data   <= '0;
            req_cnt    <= '0;
            resp_cnt   <= '0;
        end else if (line_req_xfer) begin
            lat_type   <= bus.cache2mem_reqstream_msg[175:172];
            lat_opaque <= bus.cache2mem_reqstream_msg[171:164];
            lat_base   <= bus.cache2mem_reqstream_msg[163:136];
            lat_data   <= bus.cache2mem_reqstream_msg[127:0];
            asm_data   <= '0;
            req_cnt    <= '0;
            resp_cnt   <= '0;
        end else begin
            if (word_req_xfer && (req_cnt != 3'(NUM_BEATS))) begin
                req_cnt <= req_cnt + 3'd1;
            end
            if (word_resp_xfer) begin
                // Memory is in-order, so the slot follows resp_cnt; non-read slots stay zero.
                if (lat_type == 4'd0) begin
                    asm_data[{resp_idx, 5'b0} +: 32] <= bus.mem_respstream_msg[31:0];
                end
                resp_cnt <= resp_cnt + 3'd1;
            end
        end
    end

    // Every output is forced low while reset is held, independent of state.
    always_comb begin
        bus.cache2mem_reqstream_rdy  = 1'b0;
        bus.cache2mem_respstream_val = 1'b0;
        bus.cache2mem_respstream_msg = '0;
        bus.mem_reqstream_val        = 1'b0;
        bus.mem_reqstream_msg        = '0;
        bus.mem_respstream_rdy       = 1'b0;
        if (reset) begin
            bus.cache2mem_reqstream_rdy  = line_req_rdy;
            bus.cache2mem_respstream_val = line_resp_val;
            bus.cache2mem_respstream_msg = line_resp_msg;
            bus.mem_reqstream_val        = word_req_val;
            bus.mem_reqstream_msg        = word_req_msg;
            bus.mem_respstream_rdy       = word_resp_rdy;
        end
    end
endmodule

// File: tb/tb_lab3_mem_line_to_word_adapter.sv
// Randomized bench for the line-to-word adapter with an in-order memory model and line-level reference.
module tb_lab3_mem_line_to_word_adapter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  typedef struct {
    logic [31:0] data;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] mem [bit [31:0]];

  lab3_mem_line_to_word_adapter_if bus ();

  lab3_mem_line_to_word_adapter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic idle_inputs();
    bus.cache2mem_reqstream_val  = 1'b0;
    bus.cache2mem_reqstream_msg  = '0;
    bus.cache2mem_respstream_rdy = 1'b0;
    bus.mem_reqstream_rdy        = 1'b0;
    bus.mem_respstream_val       = 1'b0;
    bus.mem_respstream_msg       = '0;
  endtask

  // Entered and left just after a falling edge. Cycle 0 is the cycle the line request is accepted.
  task automatic run_line(input logic [3:0] typ, input logic [7:0] opq, input logic [31:0] addr,
                          input logic [127:0] data, input int rdy_mode, input int max_dly,
                          input int hold, input bit chk_lat, input int abort_mode);
    logic [77:0]  exp_req [4];
    logic [145:0] exp_resp;
    logic [127:0] rd_line;
    logic [145:0] first_msg;
    logic [31:0]  base;
    logic         s_mreq_val, s_mresp_rdy, s_cresp_val, s_creq_rdy;
    logic [77:0]  s_mreq_msg;
    logic [145:0] s_cresp_msg;
    int           nreq, nresp, seen_val, last_due, dv, acc_wait;
    bit           done, aborted;

    base = {addr[31:4], 4'h0};
    for (int i = 0; i < 4; i++) begin
      exp_req[i] = {typ, 6'b0, 2'(i), base + 32'(4 * i), 2'b00, data[32*i +: 32]};
      rd_line[32*i +: 32] = mem_rd(base + 32'(4 * i));
    end
    exp_resp = {typ, opq, 2'b00, 4'h0, (typ == 4'd0) ? rd_line : 128'h0};
    pend.delete();
    nreq = 0; nresp = 0; seen_val = 0; last_due = 0; done = 0; aborted = 0;
    first_msg = '0;

    bus.cache2mem_reqstream_val = 1'b1;
    bus.cache2mem_reqstream_msg = {typ, opq, addr, 4'($urandom), data};
    acc_wait = -1;
    for (int w = 0; w < 20; w++) begin
      if (bus.cache2mem_reqstream_rdy === 1'b1) begin
        acc_wait = w;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (acc_wait < 0 || (chk_lat && acc_wait != 0)) begin
      bad++;
      $display("FAIL line_accept: accepted after %0d cycles (-1 = never), required %0s",
               acc_wait, chk_lat ? "0" : "within 20");
      if (acc_wait < 0) begin
        idle_inputs();
        return;
      end
    end
    @(negedge clk);
    bus.cache2mem_reqstream_val = 1'b0;
    bus.cache2mem_reqstream_msg = 176'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});

    for (int c = 1; c < 200; c++) begin
      if ((abort_mode == 1 && nreq >= 2) || (abort_mode == 2 && seen_val >= 2)) begin
        aborted = 1;
        break;
      end
      s_mreq_val  = bus.mem_reqstream_val;
      s_mreq_msg  = bus.mem_reqstream_msg;
      s_mresp_rdy = bus.mem_respstream_rdy;
      s_cresp_val = bus.cache2mem_respstream_val;
      s_cresp_msg = bus.cache2mem_respstream_msg;
      s_creq_rdy  = bus.cache2mem_reqstream_rdy;

      case (rdy_mode)
        0:       bus.mem_reqstream_rdy = 1'b1;
        1:       bus.mem_reqstream_rdy = (c % 2 == 1);
        default: bus.mem_reqstream_rdy = 1'($urandom_range(0, 1));
      endcase
      if (pend.size() > 0 && pend[0].due <= c) begin
        bus.mem_respstream_val = 1'b1;
        bus.mem_respstream_msg = {typ, 8'($urandom), 2'($urandom), 2'($urandom), pend[0].data};
      end else begin
        bus.mem_respstream_val = 1'b0;
        bus.mem_respstream_msg = 48'({$urandom, $urandom});
      end
      bus.cache2mem_respstream_rdy = (seen_val >= hold);

      total++;
      if (s_creq_rdy !== 1'b0) begin
        bad++;
        $display("FAIL busy_rdy: cycle %0d cache2mem_reqstream_rdy=%b, required 0", c, s_creq_rdy);
      end
      total++;
      if (s_mresp_rdy !== 1'b0 && nresp >= nreq) begin
        bad++;
        $display("FAIL resp_outrun: cycle %0d mem_respstream_rdy=%b with %0d outstanding, required 0",
                 c, s_mresp_rdy, nreq - nresp);
      end

      if (s_mreq_val === 1'b1 && bus.mem_reqstream_rdy === 1'b1) begin
        total++;
        if (nreq >= 4) begin
          bad++;
          $display("FAIL extra_word_req: word request #%0d msg=%h, required at most 4", nreq, s_mreq_msg);
        end else if (s_mreq_msg !== exp_req[nreq]) begin
          bad++;
          $display("FAIL word_req%0d: msg=%h, required %h", nreq, s_mreq_msg, exp_req[nreq]);
        end
        if (chk_lat) begin
          total++;
          if (c != nreq + 1) begin
            bad++;
            $display("FAIL word_req_cycle: beat %0d at cycle %0d, required %0d", nreq, c, nreq + 1);
          end
        end
        if (typ != 4'd0) mem[s_mreq_msg[65:34]] = s_mreq_msg[31:0];
        dv = c + 1 + ((max_dly > 0) ? int'($urandom_range(0, max_dly)) : 0);
        if (dv < last_due) dv = last_due;
        last_due = dv;
        pend.push_back('{data: (typ == 4'd0) ? mem_rd(s_mreq_msg[65:34]) : $urandom, due: dv});
        nreq++;
      end

      if (s_mresp_rdy === 1'b1 && bus.mem_respstream_val === 1'b1) begin
        pend.delete(0);
        nresp++;
        if (chk_lat) begin
          total++;
          if (c != nresp + 1) begin
            bad++;
            $display("FAIL word_resp_cycle: response %0d at cycle %0d, required %0d", nresp - 1, c, nresp + 1);
          end
        end
      end

      if (s_cresp_val === 1'b1) begin
        if (seen_val == 0) begin
          first_msg = s_cresp_msg;
          total++;
          if (nresp != 4) begin
            bad++;
            $display("FAIL early_resp: line response with %0d word responses, required 4", nresp);
          end
          if (chk_lat) begin
            total++;
            if (c != 6) begin
              bad++;
              $display("FAIL line_resp_cycle: line response at cycle %0d, required 6", c);
            end
          end
        end else begin
          total++;
          if (s_cresp_msg !== first_msg) begin
            bad++;
            $display("FAIL resp_stable: msg=%h, required %h", s_cresp_msg, first_msg);
          end
        end
        seen_val++;
        if (bus.cache2mem_respstream_rdy === 1'b1) begin
          total++;
          if (s_cresp_msg !== exp_resp) begin
            bad++;
            $display("FAIL line_resp: msg=%h, required %h", s_cresp_msg, exp_resp);
          end
          done = 1;
        end
      end
      @(negedge clk);
      if (done) break;
    end

    if (aborted) begin
      idle_inputs();
      bus.mem_reqstream_rdy        = 1'b1;
      bus.cache2mem_respstream_rdy = 1'b1;
      reset = 1'b0;
      #1;
      total++;
      if ({bus.cache2mem_reqstream_rdy, bus.cache2mem_respstream_val, bus.cache2mem_respstream_msg,
           bus.mem_reqstream_val, bus.mem_reqstream_msg, bus.mem_respstream_rdy} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: creq_rdy=%b cresp_val=%b mreq_val=%b mresp_rdy=%b cresp_msg=%h mreq_msg=%h, required all 0",
                 bus.cache2mem_reqstream_rdy, bus.cache2mem_respstream_val, bus.mem_reqstream_val,
                 bus.mem_respstream_rdy, bus.cache2mem_respstream_msg, bus.mem_reqstream_msg);
      end
      #1;
      reset = 1'b1;
      #1;
      total++;
      if (bus.cache2mem_reqstream_rdy !== 1'b1 || bus.mem_reqstream_val !== 1'b0 ||
          bus.cache2mem_respstream_val !== 1'b0) begin
        bad++;
        $display("FAIL reset_release: creq_rdy=%b mreq_val=%b cresp_val=%b, required 1 0 0",
                 bus.cache2mem_reqstream_rdy, bus.mem_reqstream_val, bus.cache2mem_respstream_val);
      end
      pend.delete();
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        total++;
        if (bus.cache2mem_reqstream_rdy !== 1'b1 || bus.mem_reqstream_val !== 1'b0 ||
            bus.cache2mem_respstream_val !== 1'b0 || bus.mem_respstream_rdy !== 1'b0) begin
          bad++;
          $display("FAIL post_reset_idle: creq_rdy=%b mreq_val=%b cresp_val=%b mresp_rdy=%b, required 1 0 0 0",
                   bus.cache2mem_reqstream_rdy, bus.mem_reqstream_val,
                   bus.cache2mem_respstream_val, bus.mem_respstream_rdy);
        end
      end
    end else if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d word reqs, %0d word resps, line resp not seen, required completion", nreq, nresp);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    bus.cache2mem_reqstream_val = 1'b1;
    bus.cache2mem_reqstream_msg = 176'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    bus.mem_respstream_val      = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.cache2mem_reqstream_rdy, bus.cache2mem_respstream_val, bus.cache2mem_respstream_msg,
         bus.mem_reqstream_val, bus.mem_reqstream_msg, bus.mem_respstream_rdy} !== '0) begin
      bad++;
      $display("FAIL reset_state: creq_rdy=%b cresp_val=%b mreq_val=%b mresp_rdy=%b, required all 0",
               bus.cache2mem_reqstream_rdy, bus.cache2mem_respstream_val,
               bus.mem_reqstream_val, bus.mem_respstream_rdy);
    end
    idle_inputs();
    reset = 1'b1;
    #1;
    total++;
    if (bus.cache2mem_reqstream_rdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_rdy: cache2mem_reqstream_rdy=%b, required 1", bus.cache2mem_reqstream_rdy);
    end
    @(negedge clk);
    total++;
    if (bus.mem_reqstream_val !== 1'b0 || bus.cache2mem_respstream_val !== 1'b0 ||
        bus.cache2mem_reqstream_rdy !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_reset: mreq_val=%b cresp_val=%b creq_rdy=%b, required 0 0 1",
               bus.mem_reqstream_val, bus.cache2mem_respstream_val, bus.cache2mem_reqstream_rdy);
    end
  endtask

  task automatic test_read();
    mem[32'h0000_1000] = 32'h11;
    mem[32'h0000_1004] = 32'h22;
    mem[32'h0000_1008] = 32'h33;
    mem[32'h0000_100C] = 32'h44;
    run_line(4'd0, 8'h5A, 32'h0000_1004, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 1, 0);
  endtask

  task automatic test_write();
    run_line(4'd1, 8'hC3, 32'h0000_2000, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, 0, 0, 0, 1, 0);
    run_line(4'd2, 8'h07, 32'h0000_300B, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 1, 0);
    run_line(4'd3, 8'hE1, 32'h0000_4010, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 1, 0);
  endtask

  task automatic test_flow_control();
    run_line(4'd0, 8'h21, 32'h0000_5000, {$urandom, $urandom, $urandom, $urandom}, 1, 3, 0, 0, 0);
    run_line(4'd0, 8'h22, 32'h0000_5010, {$urandom, $urandom, $urandom, $urandom}, 2, 4, 0, 0, 0);
    run_line(4'd1, 8'h23, 32'h0000_5020, {$urandom, $urandom, $urandom, $urandom}, 2, 2, 0, 0, 0);
  endtask

  task automatic test_resp_hold();
    run_line(4'd0, 8'h99, 32'h0000_6000, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 5, 0, 0);
    run_line(4'd0, 8'h9A, 32'h0000_6010, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    run_line(4'd0, 8'h31, 32'h0000_7000, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 0, 1);
    run_line(4'd1, 8'h32, 32'h0000_7010, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 100, 0, 2);
    run_line(4'd0, 8'h33, 32'h0000_7020, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      run_line(4'd0, 8'(8'h40 + n), 32'h0000_8000 + 32'(16 * n),
               {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_line(4'($urandom_range(0, 3)), 8'($urandom), 32'($urandom_range(0, 32'h0000_FFFF)),
               {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_read();
    test_write();
    test_flow_control();
    test_resp_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
